// File: rtl/point_slave_arbiter.sv
// Round-robin arbiter that funnels beat bursts from NREQ requesters onto one point-slave link.
// Optional idle-beat grant watchdog is compiled in with POINT_SLAVE_ARBITER_TIMEOUT_EN.
module point_slave_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            last,
    input  logic [NREQ-1:0]            beat_valid,
    input  logic [NREQ*WIDTH-1:0]      beat_data,
    output logic [NREQ-1:0]            gnt,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_valid,
    output logic [$clog2(NREQ)-1:0]    tx_src,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int SW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ out of range");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST out of range");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t         state, state_next;
    logic [SW-1:0]  ptr, gidx, sel, idx;
    logic           found;
    logic [7:0]     count, count_inc;
    logic           accept, done, tmo;
    logic [WIDTH-1:0] g_data;

    // Rotating search: the last granted index has the lowest priority.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = SW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign accept    = (state == GRANT) && beat_valid[gidx];
    assign g_data    = beat_data[gidx*WIDTH +: WIDTH];
    assign count_inc = count + 8'd1;
    assign done      = (state == GRANT) &&
                       ((accept && (last[gidx] || count_inc == 8'(MAX_BURST))) ||
                        !req[gidx] || tmo);
    assign busy      = (state != IDLE);

`ifdef POINT_SLAVE_ARBITER_TIMEOUT_EN
    logic [7:0] idle_cnt, idle_inc;

    assign idle_inc = idle_cnt + 8'd1;
    assign tmo      = (state == GRANT) && !accept && (idle_inc == 8'(TIMEOUT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo;
            if (state != GRANT || accept || done)
                idle_cnt <= 8'd0;
            else
                idle_cnt <= idle_inc;
        end
    end
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = GRANT;
            GRANT:   if (done) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_src   <= '0;
            count    <= 8'd0;
            ptr      <= SW'(NREQ - 1);
            gidx     <= '0;
        end else begin
            tx_valid <= accept;
            if (accept) begin
                tx_data <= g_data;
                tx_src  <= gidx;
                count   <= count_inc;
            end
            if (state == IDLE && (|req)) begin
                gidx  <= sel;
                gnt   <= NREQ'(1) << sel;
                count <= 8'd0;
            end
            if (done) begin
                gnt <= '0;
                ptr <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_point_slave_arbiter.sv
// Directed bench for point_slave_arbiter: vector table for single bursts and rotation,
// hand-written sequences for burst limit, req drop, mid-burst reset and the watchdog.
module tb_point_slave_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0, last = '0, beat_valid = '0;
    logic [31:0] beat_data = '0;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [1:0]  tx_src;
    logic        busy, timeout_err;

    int passed = 0;
    int total  = 0;

    point_slave_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .last(last),
        .beat_valid(beat_valid), .beat_data(beat_data), .gnt(gnt),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_src(tx_src),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  req, last, bv;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        txv;
        logic [7:0]  txd;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = '0; last = '0; beat_valid = '0; beat_data = '0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [3:0] b,
                        input logic [31:0] d);
        @(negedge clock);
        req = r; last = l; beat_valid = b; beat_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] b, input logic [31:0] d, input logic [3:0] g,
                       input logic v, input logic [7:0] td, input logic [1:0] s,
                       input logic bz);
        vec_t e;
        e.rst = rst; e.req = r; e.last = l; e.bv = b; e.data = d;
        e.gnt = g; e.txv = v; e.txd = td; e.src = s; e.busy = bz;
        vt.push_back(e);
    endtask

    int drop_at, terr_cnt;

    initial begin
        // single 3-beat burst from requester 1
        add(1, 4'b0010, 4'b0000, 4'b0000, 32'h0,        4'b0010, 0, 8'h00, 2'd0, 1);
        add(0, 4'b0010, 4'b0000, 4'b0010, 32'h0000A100, 4'b0010, 1, 8'hA1, 2'd1, 1);
        add(0, 4'b0010, 4'b0000, 4'b0010, 32'h0000A200, 4'b0010, 1, 8'hA2, 2'd1, 1);
        add(0, 4'b0010, 4'b0010, 4'b0010, 32'h0000A300, 4'b0000, 1, 8'hA3, 2'd1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        4'b0000, 0, 8'hA3, 2'd1, 0);
        // all requesting, one beat each with last: rotation 0,1,2,3,0
        add(1, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0001, 0, 8'h00, 2'd0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 1, 8'hB0, 2'd0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 0, 8'hB0, 2'd0, 0);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0010, 0, 8'hB0, 2'd0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 1, 8'hB1, 2'd1, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 0, 8'hB1, 2'd1, 0);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0100, 0, 8'hB1, 2'd1, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 1, 8'hB2, 2'd2, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 0, 8'hB2, 2'd2, 0);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b1000, 0, 8'hB2, 2'd2, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 1, 8'hB3, 2'd3, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 0, 8'hB3, 2'd3, 0);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0001, 0, 8'hB3, 2'd3, 1);
        add(0, 4'hF, 4'hF, 4'hF, 32'hB3B2B1B0, 4'b0000, 1, 8'hB0, 2'd0, 1);

        // reset state
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);
        chk("rst_src", 32'(tx_src), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            step(vt[i].req, vt[i].last, vt[i].bv, vt[i].data);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
            chk($sformatf("v%0d_txv", i), 32'(tx_valid), 32'(vt[i].txv));
            chk($sformatf("v%0d_txd", i), 32'(tx_data), 32'(vt[i].txd));
            chk($sformatf("v%0d_src", i), 32'(tx_src), 32'(vt[i].src));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("v%0d_terr", i), 32'(timeout_err), 32'h0);
        end

        // burst capped at 4 beats, then pending requester 0 served before 2
        do_reset();
        step(4'b0100, 4'b0, 4'b0, 32'h0);
        chk("mb_gnt0", 32'(gnt), 32'h4);
        for (int n = 1; n <= 4; n++) begin
            step(4'b0101, 4'b0, 4'b0100, 32'(8'hC0 + n) << 16);
            chk($sformatf("mb_txv%0d", n), 32'(tx_valid), 32'h1);
            chk($sformatf("mb_txd%0d", n), 32'(tx_data), 32'(8'hC0 + n));
            chk($sformatf("mb_gnt%0d", n), 32'(gnt), (n < 4) ? 32'h4 : 32'h0);
        end
        step(4'b0101, 4'b0, 4'b0100, 32'h00C50000);
        chk("mb_gap_txv", 32'(tx_valid), 32'h0);
        chk("mb_gap_gnt", 32'(gnt), 32'h0);
        step(4'b0101, 4'b0, 4'b0100, 32'h00C50000);
        chk("mb_next_gnt", 32'(gnt), 32'h1);
        step(4'b0100, 4'b0, 4'b0, 32'h0);
        chk("mb_drop_gnt", 32'(gnt), 32'h0);
        step(4'b0100, 4'b0, 4'b0, 32'h0);
        chk("mb_idle_busy", 32'(busy), 32'h0);
        step(4'b0100, 4'b0, 4'b0, 32'h0);
        chk("mb_regrant", 32'(gnt), 32'h4);

        // req dropped together with the final beat
        do_reset();
        step(4'b0001, 4'b0, 4'b0, 32'h0);
        chk("rd_gnt", 32'(gnt), 32'h1);
        step(4'b0000, 4'b0, 4'b0001, 32'h00000055);
        chk("rd_txv", 32'(tx_valid), 32'h1);
        chk("rd_txd", 32'(tx_data), 32'h55);
        chk("rd_src", 32'(tx_src), 32'h0);
        chk("rd_gap_gnt", 32'(gnt), 32'h0);
        chk("rd_gap_busy", 32'(busy), 32'h1);
        step(4'b0000, 4'b0, 4'b0, 32'h0);
        chk("rd_idle_busy", 32'(busy), 32'h0);
        chk("rd_idle_txv", 32'(tx_valid), 32'h0);

        // asynchronous reset in the middle of a burst
        do_reset();
        step(4'b0100, 4'b0, 4'b0, 32'h0);
        chk("ar_gnt", 32'(gnt), 32'h4);
        step(4'b0100, 4'b0, 4'b0100, 32'h00D10000);
        chk("ar_beat1", 32'(tx_data), 32'hD1);
        @(negedge clock);
        beat_valid = 4'b0100; beat_data = 32'h00D20000;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(gnt), 32'h0);
        chk("ar_txv0", 32'(tx_valid), 32'h0);
        chk("ar_txd0", 32'(tx_data), 32'h0);
        chk("ar_busy0", 32'(busy), 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        req = 4'b0110; beat_valid = 4'b0110;
        @(posedge clock);
        #1;
        chk("ar_post_txv", 32'(tx_valid), 32'h0);
        chk("ar_post_gnt", 32'(gnt), 32'h2);

        // granted requester never sends a beat
        do_reset();
        step(4'b1000, 4'b0, 4'b0, 32'h0);
        chk("to_gnt", 32'(gnt), 32'h8);
        drop_at = 0;
        terr_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            step(4'b1000, 4'b0, 4'b0, 32'h0);
            if (gnt == 4'b0 && drop_at == 0) drop_at = i;
            if (timeout_err) terr_cnt++;
        end
`ifdef POINT_SLAVE_ARBITER_TIMEOUT_EN
        chk("to_drop_at", 32'(drop_at), 32'd16);
        chk("to_err_cnt", 32'(terr_cnt), 32'd1);
`else
        chk("to_drop_at", 32'(drop_at), 32'd0);
        chk("to_err_cnt", 32'(terr_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/point_slave_arbiter.md
POINT_SLAVE_ARBITER -- requirements
Module: point_slave_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of one beat; equals WIDTH_I of the downstream point-slave link.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..255.
REQ-004 SHALL have parameter TIMEOUT, default 16: idle-beat limit when REQ-030 is compiled in, legal range 2..255.
REQ-005 SHALL have ports:
  - clock  in  1  single clock, rising edge, supplied by the bus.
  - reset_n  in  1  asynchronous active-low reset.
  - req  in  NREQ  per-requester bus request, level.
  - last  in  NREQ  marks the final beat of a requester's burst; sampled only with beat_valid.
  - beat_valid  in  NREQ  per-requester beat strobe.
  - beat_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
  - gnt  out  NREQ  one-hot grant, registered.
  - tx_data  out  WIDTH  beat to the link data_i.
  - tx_valid  out  1  tx_data carries a new beat this cycle.
  - tx_src  out  clog2(NREQ)  index of the beat's source.
  - busy  out  1  high in GRANT or GAP.
  - timeout_err  out  1  one-cycle pulse on grant revocation.

Function
REQ-010 SHALL implement states IDLE, GRANT and GAP.
REQ-011 In IDLE with req != 0, SHALL select the first asserted req searching upward from (ptr+1) mod NREQ.
  - The selection SHALL take effect next edge: gnt one-hot, state GRANT, beat count 0.
REQ-012 In IDLE with req == 0, SHALL hold gnt = 0 and stay in IDLE.
REQ-013 In GRANT with granted index g, each cycle with beat_valid[g] = 1 SHALL register on the next edge:
  - tx_data = beat_data[g], tx_src = g, tx_valid = 1;
  - beat count incremented.
  Latency is exactly 1 cycle.
REQ-014 tx_valid SHALL be 0 on cycles with no accepted beat; tx_data and tx_src SHALL hold their previous values.
REQ-015 beat_valid and beat_data of non-granted requesters SHALL be ignored.
REQ-016 GRANT SHALL terminate, moving to GAP with gnt = 0 on the next edge, on any of:
  - an accepted beat with last[g] = 1;
  - an accepted beat making the count equal MAX_BURST;
  - req[g] = 0.
REQ-017 If req[g] falls in the same cycle as beat_valid[g] = 1, the beat SHALL still be accepted before termination.
REQ-018 On leaving GRANT, ptr SHALL be updated to g.
REQ-019 GAP SHALL last exactly one cycle, then return to IDLE; no grant is issued in GAP.
REQ-020 Beat count SHALL be 8 bits, saturate-free, and cleared on entry to GRANT.
REQ-021 A requester whose req stays high SHALL be re-granted only after all other asserted requesters, giving round-robin fairness.

Reset
REQ-025 reset_n low SHALL asynchronously force:
  - state IDLE, gnt = 0, tx_valid = 0, tx_data = 0, tx_src = 0;
  - busy = 0, timeout_err = 0, count = 0, ptr = NREQ-1.
REQ-026 Reset asserted mid-burst SHALL discard the burst, with no further tx_valid.
  - After release, first arbitration SHALL favour requester 0.

Configuration
REQ-030 With macro POINT_SLAVE_ARBITER_TIMEOUT_EN defined:
  - an 8-bit counter SHALL count consecutive GRANT cycles with beat_valid[g] = 0, cleared on any accepted beat.
  - When the counter reaches TIMEOUT, the grant SHALL terminate as in REQ-016 and timeout_err SHALL pulse for 1 cycle.
REQ-031 Without the macro, no counter SHALL exist and timeout_err SHALL be constant 0.

Verification
REQ-040 req = 0010, requester 1 sends 3 beats 0xA1, 0xA2, 0xA3 with last on the third:
  - gnt = 0010 one cycle after req;
  - tx_valid 3 cycles with tx_src = 1 and matching data;
  - 1 GAP cycle, then IDLE.
REQ-041 req = 1111 held, 1 beat each with last:
  - grants in order 0, 1, 2, 3, 0, each separated by a GAP cycle.
REQ-042 MAX_BURST = 4, requester 2 streams 6 beats with no last:
  - grant ends after beat 4;
  - requester 2 is re-granted only after other pending requesters.
REQ-043 Requester 0 drops req in the same cycle as beat 0x55:
  - 0x55 appears on tx_data with tx_valid;
  - then GAP.
REQ-044 reset_n pulsed low during beat 2 of a burst:
  - all outputs 0 immediately, no beat after release;
  - next grant goes to the lowest asserted req.
REQ-045 Macro defined, TIMEOUT = 16, granted requester never asserts beat_valid:
  - gnt drops after 16 cycles;
  - timeout_err high exactly 1 cycle.
  Without the macro, the grant persists while req is held.
